sound_bus_controller: RTL and testbench
=======================================

Name: sound_bus_controller

Overview:
- Parametrised successor to the sound-board address decoder.
- Replaces fixed 2/3-bit decode trees with a table of N base/mask regions.
- Adds registered active-low chip selects, per-region wait-state insertion with a RDY handshake, and single-cycle qualified read/write strobes.
- Sits between the sound 6502 bus (RD02/WR02) and the ROM/RAM/IO/68k-mailbox selects.

Parameters:
- ADDR_W, 16: CPU address width.
- NUM_REGIONS, 4: number of decode regions; cs_l width.
- WAIT_W, 4: wait-state counter width.
- REGION_BASE, {16'h8000,16'h4000,16'h1000,16'h0000}: packed NUM_REGIONS*ADDR_W; region i base is slice i.
- REGION_MASK, {16'h8000,16'hC000,16'hF800,16'hF000}: packed; bits compared for region i.
- REGION_WAIT, {4'd1,4'd1,4'd2,4'd0}: packed NUM_REGIONS*WAIT_W; wait states per region.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  async active-low reset.
- cyc_start  in  1  one-cycle pulse; addr/RD02/WR02 valid this cycle.
- addr  in  ADDR_W  CPU address.
- RD02  in  1  active-low read request.
- WR02  in  1  active-low write request.
- cs_l  out  NUM_REGIONS  active-low region selects, one-hot-low or all high.
- rd_strobe_l  out  1  active-low one-cycle read strobe.
- wr_strobe_l  out  1  active-low one-cycle write strobe.
- rdy  out  1  high = CPU may proceed; low = stall.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset: async on rst_l low. cs_l all 1, rd_strobe_l=1, wr_strobe_l=1, rdy=1, busy=0, FSM=IDLE, counter=0. Reset mid-cycle aborts the cycle immediately; no strobe is issued.
- Decode: hit_i = ((addr & MASK_i) == (BASE_i & MASK_i)). Lowest index hit wins (priority); at most one cs_l bit low.
- Request: valid when exactly one of RD02/WR02 is low. Both low or both high at cyc_start: ignored, FSM stays IDLE.
- IDLE: on cyc_start with a valid request, latch direction, hit index and W = REGION_WAIT[hit] → ACCESS.
- ACCESS (entered cycle 1):
  - cs_l[hit]=0; busy=1; counter=W.
  - If W>0: rdy=0 and go to WAIT.
  - If W=0: go straight to STROBE.
- WAIT: counter decrements each cycle; cs_l held; rdy=0. When counter reaches 1 → STROBE.
- STROBE (cycle 1+W):
  - rd_strobe_l or wr_strobe_l = 0 for exactly one cycle; rdy=1; cs_l held.
  - Next state IDLE.
- IDLE (cycle 2+W): cs_l all high, busy=0.
- Timing summary: strobe at cycle 1+W after cyc_start; rdy low for exactly W cycles (cycles 1..W).
- cyc_start while busy: ignored, no queueing; the in-flight cycle is unaffected.
- Back-to-back: cyc_start in the cycle FSM returns to IDLE is accepted.
- Unmapped address (no hit): cycle runs with W=0, all cs_l high, strobe still issued (open-bus behaviour).
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SNDBUS_UNMAPPED_TRAP_EN.
- Defined:
  - Adds outputs unmapped_l (1 bit, sticky, active-low) and unmapped_cnt (8 bits, saturating at 8'hFF).
  - An unmapped cycle sets unmapped_l=0, increments unmapped_cnt, and suppresses the strobe.
  - Both cleared only by reset; reset values unmapped_l=1, unmapped_cnt=0.
- Undefined: ports absent; unmapped cycles behave as above (strobe issued).

Test Plan:
- Reset with defaults → cs_l=4'b1111, rd/wr strobes=1, rdy=1, busy=0. Assert rst_l low during WAIT → all outputs return to reset values the same cycle; no strobe.
- Read 16'h0123 (region0, W=0) → cs_l=4'b1110 at cycle 1; rd_strobe_l=0 at cycle 1; rdy never low; busy=0 at cycle 2.
- Write 16'h1040 (region1, W=2) → cs_l=4'b1101 cycles 1-3; rdy=0 cycles 1-2; wr_strobe_l=0 at cycle 3; cs_l=4'b1111 at cycle 4.
- Read 16'hC000 → region3 wins over region2? Mask: region2 (mask C000, base 4000) misses, region3 hits. cs_l=4'b0111; strobe at cycle 2. Override params so regions 2 and 3 both hit → lower index asserted only.
- cyc_start at cycle 2 during a region1 access → ignored, strobe timing unchanged. cyc_start with RD02=WR02=0 → busy stays 0.
- Read 16'h3000 (unmapped) → cs_l all high.
  - Without SNDBUS_UNMAPPED_TRAP_EN: rd_strobe_l=0 at cycle 1.
  - With SNDBUS_UNMAPPED_TRAP_EN: no strobe, unmapped_l=0, unmapped_cnt=1. 300 unmapped cycles → unmapped_cnt=8'hFF.

Source files
------------

// File: rtl/sound_bus_controller_if.sv
// sound_bus_controller_if
//   Bundle of the sound-CPU bus request signals and the decoded select,
//   strobe and handshake outputs of sound_bus_controller.
//   master : CPU / bus side, drives the request and observes the selects.
//   slave  : the controller itself.
//   Optional: SNDBUS_UNMAPPED_TRAP_EN adds unmapped_l and unmapped_cnt.

interface sound_bus_controller_if #(
   parameter int ADDR_W      = 16,
   parameter int NUM_REGIONS = 4
);
   // request side
   logic                   cyc_start;
   logic [ADDR_W-1:0]      addr;
   logic                   RD02;
   logic                   WR02;

   // decoded outputs
   logic [NUM_REGIONS-1:0] cs_l;
   logic                   rd_strobe_l;
   logic                   wr_strobe_l;
   logic                   rdy;
   logic                   busy;

`ifdef SNDBUS_UNMAPPED_TRAP_EN
   logic                   unmapped_l;
   logic [7:0]             unmapped_cnt;
`endif

   modport master (
      output cyc_start,
      output addr,
      output RD02,
      output WR02,
      input  cs_l,
      input  rd_strobe_l,
      input  wr_strobe_l,
      input  rdy,
`ifdef SNDBUS_UNMAPPED_TRAP_EN
      input  unmapped_l,
      input  unmapped_cnt,
`endif
      input  busy
   );

   modport slave (
      input  cyc_start,
      input  addr,
      input  RD02,
      input  WR02,
      output cs_l,
      output rd_strobe_l,
      output wr_strobe_l,
      output rdy,
`ifdef SNDBUS_UNMAPPED_TRAP_EN
      output unmapped_l,
      output unmapped_cnt,
`endif
      output busy
   );

endinterface

// File: rtl/sound_bus_controller.sv
// sound_bus_controller
//   Table-driven address decoder for the sound 6502 bus. Each of NUM_REGIONS
//   regions is a base/mask pair; the lowest-index matching region wins and
//   gets its active-low chip select. Every accepted cycle runs
//   IDLE -> (ACCESS -> WAIT...) -> STROBE -> IDLE, inserting the region's
//   wait states (rdy low) before a single-cycle read or write strobe.
//   All outputs come straight from flops.
//
//   Optional feature macro: SNDBUS_UNMAPPED_TRAP_EN
//     Adds a sticky active-low unmapped_l flag and a saturating 8-bit
//     unmapped_cnt; an access that hits no region then gets no strobe.
//     Without the macro an unmapped access still strobes (open bus).

module sound_bus_controller #(
   parameter int                              ADDR_W      = 16,
   parameter int                              NUM_REGIONS = 4,
   parameter int                              WAIT_W      = 4,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = {16'h8000, 16'h4000, 16'h1000, 16'h0000},
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_MASK = {16'h8000, 16'hC000, 16'hF800, 16'hF000},
   parameter logic [NUM_REGIONS*WAIT_W-1:0]   REGION_WAIT = {4'd1, 4'd1, 4'd2, 4'd0}
) (
   input logic                   clk,
   input logic                   rst_l,
   sound_bus_controller_if.slave bus
);

`ifdef SNDBUS_UNMAPPED_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   // ACCESS is the first wait cycle, WAIT the remaining ones; a zero-wait
   // region goes from IDLE directly to STROBE so its strobe lands in cycle 1.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_STROBE = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;

   // latched cycle context
   logic [WAIT_W-1:0]      wait_cnt_r;
   logic [WAIT_W-1:0]      wait_cnt_nxt_s;
   logic [NUM_REGIONS-1:0] sel_r;          // one-hot selected region, zero = unmapped
   logic [NUM_REGIONS-1:0] sel_nxt_s;
   logic                   is_rd_r;
   logic                   is_rd_nxt_s;

   // address decode
   logic [NUM_REGIONS-1:0] hit_vec_s;
   logic [NUM_REGIONS-1:0] dec_sel_s;
   logic [WAIT_W-1:0]      dec_wait_s;
   logic                   req_valid_s;
   logic                   accept_s;

   // next values of the registered outputs
   logic [NUM_REGIONS-1:0] cs_l_nxt_s;
   logic                   strobe_nxt_s;
   logic                   rd_strobe_l_nxt_s;
   logic                   wr_strobe_l_nxt_s;
   logic                   rdy_nxt_s;
   logic                   busy_nxt_s;

   // registered outputs
   logic [NUM_REGIONS-1:0] cs_l_r;
   logic                   rd_strobe_l_r;
   logic                   wr_strobe_l_r;
   logic                   rdy_r;
   logic                   busy_r;

   // Compare the address with every region, isolate the lowest-index hit and look up its wait count
   always_comb begin
      hit_vec_s  = {NUM_REGIONS{1'b0}};
      dec_wait_s = {WAIT_W{1'b0}};
      for (int i = 0; i < NUM_REGIONS; i++) begin
         hit_vec_s[i] = ((bus.addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                         (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]));
      end
      // x & -x keeps only the least significant set bit: priority to region 0
      dec_sel_s = hit_vec_s & (~hit_vec_s + NUM_REGIONS'(1));
      for (int i = 0; i < NUM_REGIONS; i++) begin
         dec_wait_s = dec_wait_s |
                      (dec_sel_s[i] ? REGION_WAIT[i*WAIT_W +: WAIT_W] : {WAIT_W{1'b0}});
      end
   end

   // Exactly one of the active-low request lines must be asserted
   assign req_valid_s = bus.RD02 ^ bus.WR02;
   assign accept_s    = (state_r == ST_IDLE) && bus.cyc_start && req_valid_s;

   // Bus-cycle FSM: state register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= {WAIT_W{1'b0}};
         sel_r      <= {NUM_REGIONS{1'b0}};
         is_rd_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         sel_r      <= sel_nxt_s;
         is_rd_r    <= is_rd_nxt_s;
      end
   end

   // Bus-cycle FSM: next state, latched context and next output values
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      sel_nxt_s      = sel_r;
      is_rd_nxt_s    = is_rd_r;

      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               sel_nxt_s      = dec_sel_s;
               is_rd_nxt_s    = ~bus.RD02;
               wait_cnt_nxt_s = dec_wait_s;
               if (dec_wait_s == {WAIT_W{1'b0}}) begin
                  state_nxt_s = ST_STROBE;
               end else begin
                  state_nxt_s = ST_ACCESS;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS, ST_WAIT: begin
            // counter shows the wait cycles still to run, this one included
            wait_cnt_nxt_s = wait_cnt_r - WAIT_W'(1);
            if (wait_cnt_r <= WAIT_W'(1)) begin
               state_nxt_s = ST_STROBE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_STROBE: begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
            state_nxt_s    = ST_IDLE;
         end
         default: begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
            sel_nxt_s      = {NUM_REGIONS{1'b0}};
            state_nxt_s    = ST_IDLE;
         end
      endcase

      // outputs are decoded from the next state so the flops line up with it
      busy_nxt_s   = (state_nxt_s != ST_IDLE);
      rdy_nxt_s    = !((state_nxt_s == ST_ACCESS) || (state_nxt_s == ST_WAIT));
      cs_l_nxt_s   = busy_nxt_s ? ~sel_nxt_s : {NUM_REGIONS{1'b1}};
      strobe_nxt_s = (state_nxt_s == ST_STROBE) &&
                     !(TRAP_EN && (sel_nxt_s == {NUM_REGIONS{1'b0}}));
      rd_strobe_l_nxt_s = ~(strobe_nxt_s &  is_rd_nxt_s);
      wr_strobe_l_nxt_s = ~(strobe_nxt_s & ~is_rd_nxt_s);
   end

   // Output flops: selects, strobes and handshake
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cs_l_r        <= {NUM_REGIONS{1'b1}};
         rd_strobe_l_r <= 1'b1;
         wr_strobe_l_r <= 1'b1;
         rdy_r         <= 1'b1;
         busy_r        <= 1'b0;
      end else begin
         cs_l_r        <= cs_l_nxt_s;
         rd_strobe_l_r <= rd_strobe_l_nxt_s;
         wr_strobe_l_r <= wr_strobe_l_nxt_s;
         rdy_r         <= rdy_nxt_s;
         busy_r        <= busy_nxt_s;
      end
   end

   assign bus.cs_l        = cs_l_r;
   assign bus.rd_strobe_l = rd_strobe_l_r;
   assign bus.wr_strobe_l = wr_strobe_l_r;
   assign bus.rdy         = rdy_r;
   assign bus.busy        = busy_r;

`ifdef SNDBUS_UNMAPPED_TRAP_EN
   logic       unmapped_hit_s;
   logic       unmapped_l_r;
   logic [7:0] unmapped_cnt_r;

   assign unmapped_hit_s = accept_s && (dec_sel_s == {NUM_REGIONS{1'b0}});

   // Sticky unmapped-access flag and saturating counter, cleared only by reset
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         unmapped_l_r   <= 1'b1;
         unmapped_cnt_r <= 8'h00;
      end else if (unmapped_hit_s) begin
         unmapped_l_r   <= 1'b0;
         unmapped_cnt_r <= (unmapped_cnt_r == 8'hFF) ? 8'hFF : (unmapped_cnt_r + 8'h01);
      end else begin
         unmapped_l_r   <= unmapped_l_r;
         unmapped_cnt_r <= unmapped_cnt_r;
      end
   end

   assign bus.unmapped_l   = unmapped_l_r;
   assign bus.unmapped_cnt = unmapped_cnt_r;
`endif

endmodule

// File: tb/tb_sound_bus_controller.sv
// tb_sound_bus_controller
//   Randomised and directed stimulus for sound_bus_controller, checked
//   cycle by cycle against a table-based reference of the decode and the
//   access timeline. A second instance uses an overlapping region table to
//   exercise the lowest-index priority rule.
//   Optional feature macro: SNDBUS_UNMAPPED_TRAP_EN.
`timescale 1ns/1ps

module tb_sound_bus_controller;

`ifdef SNDBUS_UNMAPPED_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_l;
   logic        cyc_start;
   logic [15:0] addr;
   logic        rd02;
   logic        wr02;

   int tests_run    = 0;
   int tests_failed = 0;

`ifdef SNDBUS_UNMAPPED_TRAP_EN
   int exp_unm_cnt = 0;
   bit exp_unm_l   = 1'b1;
`endif

   sound_bus_controller_if #(.ADDR_W(16), .NUM_REGIONS(4)) bus0 ();
   sound_bus_controller_if #(.ADDR_W(16), .NUM_REGIONS(4)) bus1 ();

   assign bus0.cyc_start = cyc_start;
   assign bus0.addr      = addr;
   assign bus0.RD02      = rd02;
   assign bus0.WR02      = wr02;
   assign bus1.cyc_start = cyc_start;
   assign bus1.addr      = addr;
   assign bus1.RD02      = rd02;
   assign bus1.WR02      = wr02;

   sound_bus_controller dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus0)
   );

   // regions 2 and 3 both cover 8000-FFFF here
   sound_bus_controller #(
      .REGION_BASE ({16'h8000, 16'h8000, 16'h1000, 16'h0000}),
      .REGION_MASK ({16'h8000, 16'h8000, 16'hF800, 16'hF000}),
      .REGION_WAIT ({4'd1, 4'd3, 4'd2, 4'd0})
   ) dut_ovr (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // reference: first region (lowest index) whose masked bits match, -1 if none
   function automatic int ref_region(input logic [15:0] a, input int tbl);
      logic [15:0] base [4];
      logic [15:0] mask [4];
      base = '{16'h0000, 16'h1000, 16'h4000, 16'h8000};
      mask = '{16'hF000, 16'hF800, 16'hC000, 16'h8000};
      if (tbl == 1) begin
         base[2] = 16'h8000;
         mask[2] = 16'h8000;
      end
      for (int i = 0; i < 4; i++) begin
         if ((a & mask[i]) == (base[i] & mask[i])) return i;
      end
      return -1;
   endfunction

   function automatic int ref_wait(input int r, input int tbl);
      int w [4];
      w = '{0, 2, 1, 1};
      if (tbl == 1) w[2] = 3;
      if (r < 0) return 0;
      return w[r];
   endfunction

   // One access on the default instance, checked every cycle until it is idle again.
   // Called at a negedge; the request is driven in that same cycle (cycle 0).
   task automatic run_txn(input logic [15:0] a, input bit is_rd, input int inject_at);
      int h, w, inj;
      bit unm, strobe;
      logic [3:0] exp_cs;
      h   = ref_region(a, 0);
      w   = ref_wait(h, 0);
      unm = (h < 0);
      inj = (inject_at > w + 1) ? 0 : inject_at;
      cyc_start = 1'b1;
      addr = a;
      rd02 = !is_rd;
      wr02 = is_rd;
      for (int k = 1; k <= w + 2; k++) begin
         @(negedge clk);
         cyc_start = 1'b0;
         addr = 16'($urandom);
         rd02 = 1'($urandom);
         wr02 = 1'($urandom);
         if (k == inj) begin
            cyc_start = 1'b1;
            rd02 = 1'b0;
            wr02 = 1'b1;
         end
         exp_cs = 4'b1111;
         if (!unm && k <= w + 1) exp_cs = ~(4'b0001 << h);
         strobe = (k == w + 1) && !(TRAP && unm);

         tests_run++;
         if (bus0.cs_l !== exp_cs) begin
            tests_failed++;
            $display("FAIL cs_l addr=%h cycle=%0d got %b expected %b", a, k, bus0.cs_l, exp_cs);
         end
         tests_run++;
         if (bus0.rdy !== (k > w)) begin
            tests_failed++;
            $display("FAIL rdy addr=%h cycle=%0d got %b expected %b", a, k, bus0.rdy, (k > w));
         end
         tests_run++;
         if (bus0.busy !== (k <= w + 1)) begin
            tests_failed++;
            $display("FAIL busy addr=%h cycle=%0d got %b expected %b", a, k, bus0.busy, (k <= w + 1));
         end
         tests_run++;
         if (bus0.rd_strobe_l !== !(strobe && is_rd)) begin
            tests_failed++;
            $display("FAIL rd_strobe_l addr=%h cycle=%0d got %b expected %b", a, k,
                     bus0.rd_strobe_l, !(strobe && is_rd));
         end
         tests_run++;
         if (bus0.wr_strobe_l !== !(strobe && !is_rd)) begin
            tests_failed++;
            $display("FAIL wr_strobe_l addr=%h cycle=%0d got %b expected %b", a, k,
                     bus0.wr_strobe_l, !(strobe && !is_rd));
         end
      end
      cyc_start = 1'b0;
`ifdef SNDBUS_UNMAPPED_TRAP_EN
      if (unm) begin
         exp_unm_l = 1'b0;
         if (exp_unm_cnt < 255) exp_unm_cnt++;
      end
      tests_run++;
      if (bus0.unmapped_l !== exp_unm_l) begin
         tests_failed++;
         $display("FAIL unmapped_l addr=%h got %b expected %b", a, bus0.unmapped_l, exp_unm_l);
      end
      tests_run++;
      if (bus0.unmapped_cnt !== 8'(exp_unm_cnt)) begin
         tests_failed++;
         $display("FAIL unmapped_cnt addr=%h got %0d expected %0d", a, bus0.unmapped_cnt, exp_unm_cnt);
      end
`endif
   endtask

   task automatic check_idle(input string tag);
      tests_run++;
      if ({bus0.cs_l, bus0.rd_strobe_l, bus0.wr_strobe_l, bus0.rdy, bus0.busy} !== 8'b1111_1110) begin
         tests_failed++;
         $display("FAIL idle_%s got cs_l=%b rd=%b wr=%b rdy=%b busy=%b expected 1111 1 1 1 0", tag,
                  bus0.cs_l, bus0.rd_strobe_l, bus0.wr_strobe_l, bus0.rdy, bus0.busy);
      end
   endtask

   task automatic test_reset();
      rst_l = 1'b0;
      cyc_start = 1'b0;
      addr = 16'h0000;
      rd02 = 1'b1;
      wr02 = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst_l = 1'b1;
      @(negedge clk);
      check_idle("after_reset");
   endtask

   task automatic test_reset_mid_wait();
      cyc_start = 1'b1;
      addr = 16'h1040;
      rd02 = 1'b1;
      wr02 = 1'b0;
      @(negedge clk);
      cyc_start = 1'b0;
      tests_run++;
      if (bus0.rdy !== 1'b0 || bus0.cs_l !== 4'b1101) begin
         tests_failed++;
         $display("FAIL pre_reset_wait got rdy=%b cs_l=%b expected 0 1101", bus0.rdy, bus0.cs_l);
      end
      @(negedge clk);
      rst_l = 1'b0;
      #1;
      check_idle("reset_in_wait");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 2) rst_l = 1'b1;
         check_idle("no_strobe_after_reset");
      end
`ifdef SNDBUS_UNMAPPED_TRAP_EN
      exp_unm_cnt = 0;
      exp_unm_l   = 1'b1;
`endif
   endtask

   task automatic test_directed();
      run_txn(16'h0123, 1'b1, 0);
      @(negedge clk);
      run_txn(16'h1040, 1'b0, 0);
      @(negedge clk);
      run_txn(16'hC000, 1'b1, 0);
      @(negedge clk);
      run_txn(16'h3000, 1'b1, 0);
      @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      run_txn(16'h1040, 1'b1, 2);
      @(negedge clk);
      run_txn(16'h9000, 1'b0, 1);
      @(negedge clk);
   endtask

   task automatic test_invalid_request();
      for (int v = 0; v < 2; v++) begin
         cyc_start = 1'b1;
         addr = 16'h0123;
         rd02 = 1'(v);
         wr02 = 1'(v);
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cyc_start = 1'b0;
            check_idle("invalid_req");
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 12; n++) begin
         run_txn(16'($urandom), 1'($urandom), 0);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            test_invalid_request();
         end else begin
            run_txn(16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_priority_override();
      int h, w;
      logic [3:0] exp_cs;
      cyc_start = 1'b0;
      repeat (6) @(negedge clk);
      h = ref_region(16'hC000, 1);
      w = ref_wait(h, 1);
      cyc_start = 1'b1;
      addr = 16'hC000;
      rd02 = 1'b0;
      wr02 = 1'b1;
      for (int k = 1; k <= w + 2; k++) begin
         @(negedge clk);
         cyc_start = 1'b0;
         exp_cs = 4'b1111;
         if (k <= w + 1) exp_cs = ~(4'b0001 << h);
         tests_run++;
         if (bus1.cs_l !== exp_cs) begin
            tests_failed++;
            $display("FAIL ovr_cs_l cycle=%0d got %b expected %b", k, bus1.cs_l, exp_cs);
         end
         tests_run++;
         if (bus1.rd_strobe_l !== !(k == w + 1)) begin
            tests_failed++;
            $display("FAIL ovr_rd_strobe_l cycle=%0d got %b expected %b", k, bus1.rd_strobe_l, !(k == w + 1));
         end
         tests_run++;
         if (bus1.busy !== (k <= w + 1)) begin
            tests_failed++;
            $display("FAIL ovr_busy cycle=%0d got %b expected %b", k, bus1.busy, (k <= w + 1));
         end
      end
      repeat (2) @(negedge clk);
   endtask

`ifdef SNDBUS_UNMAPPED_TRAP_EN
   task automatic test_unmapped_saturation();
      for (int n = 0; n < 300; n++) begin
         run_txn(16'(16'h1800 + $urandom_range(0, 16'h27FF)), 1'($urandom), 0);
      end
      tests_run++;
      if (bus0.unmapped_cnt !== 8'hFF) begin
         tests_failed++;
         $display("FAIL unmapped_saturate got %h expected ff", bus0.unmapped_cnt);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_wait();
      test_busy_ignore();
      test_invalid_request();
      test_back_to_back();
      test_random();
      test_priority_override();
`ifdef SNDBUS_UNMAPPED_TRAP_EN
      test_unmapped_saturation();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
